// File: rtl/pc_sequencer.sv
// Fetch program-counter sequencer: sequential fetch, stall hold, branch/jump/rti
// redirects with a fixed flush window, level interrupt entry and a halt state.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] IRQ_VECTOR   = 32'h0000_0100,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        rti,
  input  logic        irq,
  input  logic        halt,
  output logic [31:0] pc,
  output logic        pc_en,
  output logic        flush,
  output logic        irq_ack,
  output logic [31:0] epc
);

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StFlush  = 2'd1,
    StHalted = 2'd2
  } state_e;

  localparam logic [2:0] CntInit = 3'(FLUSH_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        ie_q, ie_d;
  logic        irq_ack_q, irq_ack_d;

  logic        redirect;
  logic [31:0] redirect_target;
  logic        irq_ok;

  assign redirect        = branch_taken | jump | rti;
  assign redirect_target = branch_taken ? branch_target :
                           jump         ? jump_target   : epc_q;
  assign irq_ok          = irq & ie_q;

  // Fetch-side outputs decoded from current state; clr forces them quiet.
  always_comb begin
    pc_en = (state_q == StRun) & ~stall & ~clr;
    flush = (state_q == StFlush) & ~clr;
  end

  assign pc      = pc_q;
  assign epc     = epc_q;
  assign irq_ack = irq_ack_q;

  // Next-state selection: clr, then redirect, then per-state behaviour.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    epc_d     = epc_q;
    cnt_d     = cnt_q;
    ie_d      = ie_q;
    irq_ack_d = 1'b0;

    if (clr) begin
      state_d = StRun;
      pc_d    = RESET_PC;
      epc_d   = 32'h0;
      cnt_d   = 3'd0;
      ie_d    = 1'b1;
    end else if (redirect) begin
      state_d = StFlush;
      pc_d    = redirect_target;
      cnt_d   = CntInit;
      // A branch or jump in the same cycle wins the target, so rti is not returning.
      if (rti && !branch_taken && !jump) begin
        ie_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        StRun: begin
          if (irq_ok) begin
            state_d   = StFlush;
            epc_d     = pc_q;
            pc_d      = IRQ_VECTOR;
            cnt_d     = CntInit;
            ie_d      = 1'b0;
            irq_ack_d = 1'b1;
          end else if (halt && !stall) begin
            state_d = StHalted;
          end else if (!stall) begin
            pc_d = pc_q + 32'd1;
          end
        end
        StFlush: begin
          if (cnt_q == 3'd0) begin
            state_d = StRun;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        StHalted: begin
          if (irq_ok) begin
            state_d   = StFlush;
            epc_d     = pc_q;
            pc_d      = IRQ_VECTOR;
            cnt_d     = CntInit;
            ie_d      = 1'b0;
            irq_ack_d = 1'b1;
          end
        end
        default: begin
          state_d = StRun;
        end
      endcase
    end
  end

  // State register; reset values come through the clr branch above.
  always_ff @(posedge clk) begin
    state_q   <= state_d;
    pc_q      <= pc_d;
    epc_q     <= epc_d;
    cnt_q     <= cnt_d;
    ie_q      <= ie_d;
    irq_ack_q <= irq_ack_d;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        rti;
  logic        irq;
  logic        halt;
  logic [31:0] pc;
  logic        pc_en;
  logic        flush;
  logic        irq_ack;
  logic [31:0] epc;

  int checks_total = 0;
  int checks_pass  = 0;

  pc_sequencer dut (
    .clk          (clk),
    .clr          (clr),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .rti          (rti),
    .irq          (irq),
    .halt         (halt),
    .pc           (pc),
    .pc_en        (pc_en),
    .flush        (flush),
    .irq_ack      (irq_ack),
    .epc          (epc)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic [31:0] e_pc, input logic e_en,
                         input logic e_fl, input logic e_ack);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".pc_en"}, {31'h0, pc_en}, {31'h0, e_en});
    chk({tag, ".flush"}, {31'h0, flush}, {31'h0, e_fl});
    chk({tag, ".irq_ack"}, {31'h0, irq_ack}, {31'h0, e_ack});
  endtask

  initial begin
    clr = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    jump = 1'b0; jump_target = 32'h0; rti = 1'b0; irq = 1'b0; halt = 1'b0;

    // Reset and count.
    step();
    chk_out("rst0", 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk_out("rst1", 32'h0, 1'b0, 1'b0, 1'b0);
    chk("rst.epc", epc, 32'h0);
    clr = 1'b0;
    #1;
    chk_out("rel", 32'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk_out("count", 32'(i), 1'b1, 1'b0, 1'b0);
    end

    // Stall holds, then redirect overrides stall.
    stall = 1'b1;
    #1;
    chk("stall.pc_en", {31'h0, pc_en}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("stall", 32'h5, 1'b0, 1'b0, 1'b0);
    end
    branch_taken = 1'b1; branch_target = 32'h40;
    step();
    branch_taken = 1'b0; stall = 1'b0;
    #1;
    chk_out("br.f1", 32'h40, 1'b0, 1'b1, 1'b0);
    step();
    chk_out("br.f2", 32'h40, 1'b0, 1'b1, 1'b0);
    step();
    chk_out("br.run", 32'h40, 1'b1, 1'b0, 1'b0);
    step();
    chk_out("br.next", 32'h41, 1'b1, 1'b0, 1'b0);

    // Get to pc=0x10 and take an interrupt.
    jump = 1'b1; jump_target = 32'h10;
    step();
    jump = 1'b0;
    step();
    step();
    chk_out("j10", 32'h10, 1'b1, 1'b0, 1'b0);
    irq = 1'b1;
    step();
    chk_out("irq.entry", 32'h100, 1'b0, 1'b1, 1'b1);
    chk("irq.epc", epc, 32'h10);
    step();
    chk_out("irq.f2", 32'h100, 1'b0, 1'b1, 1'b0);
    step();
    chk_out("irq.run", 32'h100, 1'b1, 1'b0, 1'b0);
    step();
    chk_out("irq.held", 32'h101, 1'b1, 1'b0, 1'b0);
    irq = 1'b0; rti = 1'b1;
    step();
    rti = 1'b0;
    #1;
    chk_out("rti.f1", 32'h10, 1'b0, 1'b1, 1'b0);
    step();
    chk_out("rti.f2", 32'h10, 1'b0, 1'b1, 1'b0);
    step();
    chk_out("rti.run", 32'h10, 1'b1, 1'b0, 1'b0);
    step();
    chk_out("rti.next", 32'h11, 1'b1, 1'b0, 1'b0);
    irq = 1'b1;
    step();
    irq = 1'b0;
    #1;
    chk_out("irq2.entry", 32'h100, 1'b0, 1'b1, 1'b1);
    chk("irq2.epc", epc, 32'h11);
    step();
    step();

    // Re-enable interrupts via rti, then halt at pc=7 and wake on irq.
    rti = 1'b1;
    step();
    rti = 1'b0;
    step();
    step();
    chk_out("rti2.run", 32'h11, 1'b1, 1'b0, 1'b0);
    jump = 1'b1; jump_target = 32'h7;
    step();
    jump = 1'b0;
    step();
    step();
    chk_out("j7", 32'h7, 1'b1, 1'b0, 1'b0);
    halt = 1'b1;
    step();
    halt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      stall = i[0];
      step();
      chk_out("halted", 32'h7, 1'b0, 1'b0, 1'b0);
    end
    stall = 1'b0; irq = 1'b1;
    step();
    irq = 1'b0;
    #1;
    chk_out("wake", 32'h100, 1'b0, 1'b1, 1'b1);
    chk("wake.epc", epc, 32'h7);
    step();
    step();

    // Wrap at 2^32.
    jump = 1'b1; jump_target = 32'hFFFF_FFFF;
    step();
    jump = 1'b0;
    step();
    step();
    chk_out("wrap.run", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    step();
    chk_out("wrap.zero", 32'h0, 1'b1, 1'b0, 1'b0);

    // Jump on the first flush cycle restarts the window.
    jump = 1'b1; jump_target = 32'h200;
    step();
    chk_out("rs.f1", 32'h200, 1'b0, 1'b1, 1'b0);
    jump_target = 32'h300;
    step();
    jump = 1'b0;
    #1;
    chk_out("rs.f2", 32'h300, 1'b0, 1'b1, 1'b0);
    step();
    chk_out("rs.f3", 32'h300, 1'b0, 1'b1, 1'b0);
    step();
    chk_out("rs.run", 32'h300, 1'b1, 1'b0, 1'b0);

    // clr on the second flush cycle; ie is 0 going in.
    jump = 1'b1; jump_target = 32'h50;
    step();
    jump = 1'b0;
    step();
    chk_out("mf.f2", 32'h50, 1'b0, 1'b1, 1'b0);
    clr = 1'b1;
    #1;
    chk("mf.clr.flush", {31'h0, flush}, 32'h0);
    step();
    clr = 1'b0;
    #1;
    chk_out("mf.run", 32'h0, 1'b1, 1'b0, 1'b0);
    chk("mf.epc", epc, 32'h0);
    irq = 1'b1;
    step();
    irq = 1'b0;
    #1;
    chk_out("mf.ie", 32'h100, 1'b0, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", checks_pass, checks_total);
    $finish;
  end

endmodule
